// File: rtl/adc_frame_packetizer_pkg.sv
// Shared encodings for the ADC frame packetizer: FSM state codes, sync bytes and
// header geometry, plus small state-classification helpers used by the FSM.
package adc_frame_packetizer_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_IDLE   = 4'd0;
    localparam state_t ST_SYNC0  = 4'd1;
    localparam state_t ST_SYNC1  = 4'd2;
    localparam state_t ST_SEQ    = 4'd3;
    localparam state_t ST_LENH   = 4'd4;
    localparam state_t ST_LENL   = 4'd5;
    localparam state_t ST_RDREQ  = 4'd6;
    localparam state_t ST_RDWAIT = 4'd7;
    localparam state_t ST_PAYLD  = 4'd8;
    localparam state_t ST_PAD    = 4'd9;
    localparam state_t ST_CKSUM  = 4'd10;
    localparam state_t ST_DONE   = 4'd11;

    localparam logic [7:0] SYNC0_BYTE = 8'hA5;
    localparam logic [7:0] SYNC1_BYTE = 8'h5A;

    // Header states are encoded contiguously starting at ST_SYNC0.
    localparam int HDR_LEN = 5;

    function automatic logic is_header(input state_t st);
        return (st >= ST_SYNC0) && (st < 4'(ST_SYNC0 + HDR_LEN));
    endfunction

    function automatic logic emits_byte(input state_t st);
        return is_header(st) || (st == ST_PAYLD) || (st == ST_PAD) || (st == ST_CKSUM);
    endfunction

    function automatic logic in_checksum(input state_t st);
        return (st == ST_SEQ) || (st == ST_LENH) || (st == ST_LENL) ||
               (st == ST_PAYLD) || (st == ST_PAD);
    endfunction

endpackage

// File: rtl/adc_frame_packetizer_checksum.sv
// Running 8-bit frame checksum; presents the two's complement of the sum so the
// covered bytes plus the checksum byte add to zero modulo 256.
module frame_checksum_acc
    import adc_frame_packetizer_pkg::*;
(
    input  logic       Clock,
    input  logic       clear_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic [7:0] cksum_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clear_i) begin
            sum_d = 8'h00;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    // Pure datapath: every frame clears it before the first byte is added.
    always_ff @(posedge Clock) begin
        sum_q <= sum_d;
    end

    assign cksum_o = 8'h00 - sum_q;

endmodule

// File: rtl/adc_frame_packetizer.sv
// Frames bytes read from the ADC sample FIFO as sync/seq/len/payload/checksum
// packets for the UART, padding the payload when the FIFO stalls too long.
module adc_frame_packetizer
    import adc_frame_packetizer_pkg::*;
#(
    parameter int         PAYLOAD_LEN     = 256,
    parameter int         FIFO_RD_LATENCY = 1,
    parameter int         STALL_TIMEOUT   = 100000,
    parameter logic [7:0] PAD_BYTE        = 8'h00
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       enable_i,
    input  logic       fifo_not_empty_i,
    input  logic [7:0] fifo_data_i,
    input  logic       fifo_valid_i,
    output logic       fifo_rd_o,
    input  logic       tx_ready_i,
    output logic [7:0] tx_data_o,
    output logic       tx_wr_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       padded_o,
    output logic [7:0] seq_num_o
);

    localparam int          STALL_W    = $clog2(STALL_TIMEOUT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);
    localparam logic [15:0] PAY_LAST   = 16'(PAYLOAD_LEN - 1);
    localparam logic [7:0]  LEN_HI     = 8'(PAYLOAD_LEN >> 8);
    localparam logic [7:0]  LEN_LO     = 8'(PAYLOAD_LEN & 255);
    localparam logic [1:0]  RD_LAT     = 2'(FIFO_RD_LATENCY);

    state_t               state_q, state_d;
    logic [7:0]           seq_q, seq_d;
    logic                 padded_q, padded_d;
    logic [15:0]          pay_cnt_q, pay_cnt_d;
    logic [STALL_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [1:0]           rd_age_q, rd_age_d;
    logic                 wr_prev_q;
    logic [7:0]           byte_q, byte_d;

    logic       tx_fire;
    logic [7:0] tx_byte;
    logic [7:0] cksum;
    logic       ck_clear;
    logic       pay_last;

    // One-cycle guard after every write covers the UART's busy-flag latency.
    assign tx_fire  = emits_byte(state_q) && tx_ready_i && !wr_prev_q;
    assign pay_last = (pay_cnt_q == PAY_LAST);

    always_comb begin
        tx_byte = 8'h00;
        case (state_q)
            ST_SYNC0: tx_byte = SYNC0_BYTE;
            ST_SYNC1: tx_byte = SYNC1_BYTE;
            ST_SEQ:   tx_byte = seq_q;
            ST_LENH:  tx_byte = LEN_HI;
            ST_LENL:  tx_byte = LEN_LO;
            ST_PAYLD: tx_byte = byte_q;
            ST_PAD:   tx_byte = PAD_BYTE;
            ST_CKSUM: tx_byte = cksum;
            default:  tx_byte = 8'h00;
        endcase
    end

    frame_checksum_acc u_cksum (
        .Clock   (Clock),
        .clear_i (ck_clear),
        .add_i   (tx_fire && in_checksum(state_q)),
        .data_i  (tx_byte),
        .cksum_o (cksum)
    );

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        padded_d     = padded_q;
        pay_cnt_d    = pay_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        rd_age_d     = rd_age_q;
        byte_d       = byte_q;
        ck_clear     = 1'b0;
        fifo_rd_o    = 1'b0;
        frame_done_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_i && fifo_not_empty_i) begin
                    state_d     = ST_SYNC0;
                    padded_d    = 1'b0;
                    ck_clear    = 1'b1;
                    pay_cnt_d   = 16'd0;
                    stall_cnt_d = '0;
                end
            end
            ST_SYNC0: if (tx_fire) state_d = ST_SYNC1;
            ST_SYNC1: if (tx_fire) state_d = ST_SEQ;
            ST_SEQ:   if (tx_fire) state_d = ST_LENH;
            ST_LENH:  if (tx_fire) state_d = ST_LENL;
            ST_LENL:  if (tx_fire) state_d = ST_RDREQ;
            ST_RDREQ: begin
                if (fifo_not_empty_i) begin
                    fifo_rd_o   = 1'b1;
                    stall_cnt_d = '0;
                    rd_age_d    = 2'd1;
                    state_d     = ST_RDWAIT;
                end else if (stall_cnt_q == STALL_LAST) begin
                    padded_d = 1'b1;
                    state_d  = ST_PAD;
                end else begin
                    stall_cnt_d = stall_cnt_q + STALL_W'(1);
                end
            end
            ST_RDWAIT: begin
                // A valid earlier than the FIFO's read latency cannot belong to our read.
                if (fifo_valid_i && (rd_age_q >= RD_LAT)) begin
                    byte_d  = fifo_data_i;
                    state_d = ST_PAYLD;
                end else if (rd_age_q != 2'd3) begin
                    rd_age_d = rd_age_q + 2'd1;
                end
            end
            ST_PAYLD: begin
                if (tx_fire) begin
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    state_d   = pay_last ? ST_CKSUM : ST_RDREQ;
                end
            end
            ST_PAD: begin
                if (tx_fire) begin
                    pay_cnt_d = pay_cnt_q + 16'd1;
                    if (pay_last) state_d = ST_CKSUM;
                end
            end
            ST_CKSUM: if (tx_fire) state_d = ST_DONE;
            ST_DONE: begin
                frame_done_o = 1'b1;
                seq_d        = seq_q + 8'd1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            seq_q       <= 8'd0;
            padded_q    <= 1'b0;
            pay_cnt_q   <= 16'd0;
            stall_cnt_q <= '0;
            rd_age_q    <= 2'd0;
            wr_prev_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            padded_q    <= padded_d;
            pay_cnt_q   <= pay_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            rd_age_q    <= rd_age_d;
            wr_prev_q   <= tx_fire;
        end
    end

    always_ff @(posedge Clock) begin
        byte_q <= byte_d;
    end

    assign tx_wr_o   = tx_fire;
    assign tx_data_o = tx_fire ? tx_byte : 8'h00;
    assign busy_o    = (state_q != ST_IDLE);
    assign padded_o  = padded_q;
    assign seq_num_o = seq_q;

endmodule

// File: tb/tb_adc_frame_packetizer.sv
// Directed bench for adc_frame_packetizer with a FIFO model and a byte scoreboard.
module tb_adc_frame_packetizer;

    localparam int         PL    = 4;
    localparam int         STALL = 10;
    localparam logic [7:0] PADB  = 8'h00;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       enable = 1'b0;
    logic       fifo_not_empty = 1'b0;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_valid = 1'b0;
    logic       fifo_rd;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_wr;
    logic       busy;
    logic       frame_done;
    logic       padded;
    logic [7:0] seq_num;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] pl [PL];
    logic [7:0] exp_b;
    logic [7:0] seq_model = 8'd0;
    logic [7:0] fsum = 8'd0;
    int         pos = 0;
    int         wr_count = 0;
    int         rd_count = 0;
    int         done_count = 0;
    int         bp_cnt = 0;
    logic       rd_seen = 1'b0;
    logic       prev_wr = 1'b0;
    logic       bp_en = 1'b0;

    adc_frame_packetizer #(
        .PAYLOAD_LEN     (PL),
        .FIFO_RD_LATENCY (1),
        .STALL_TIMEOUT   (STALL),
        .PAD_BYTE        (PADB)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .enable_i         (enable),
        .fifo_not_empty_i (fifo_not_empty),
        .fifo_data_i      (fifo_data),
        .fifo_valid_i     (fifo_valid),
        .fifo_rd_o        (fifo_rd),
        .tx_ready_i       (tx_ready),
        .tx_data_o        (tx_data),
        .tx_wr_o          (tx_wr),
        .busy_o           (busy),
        .frame_done_o     (frame_done),
        .padded_o         (padded),
        .seq_num_o        (seq_num)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // FIFO with one-cycle read latency, plus the UART ready pattern.
    always @(posedge Clock) begin
        #1;
        fifo_valid = 1'b0;
        if (rd_seen && fifo_q.size() != 0) begin
            fifo_valid = 1'b1;
            fifo_data  = fifo_q.pop_front();
        end
        fifo_not_empty = (fifo_q.size() != 0);
        if (bp_en) begin
            bp_cnt++;
            if (bp_cnt % 3 == 0) tx_ready = ~tx_ready;
        end else begin
            bp_cnt   = 0;
            tx_ready = 1'b1;
        end
    end

    // Monitor: scoreboard compare, write-rule checks, per-frame checksum check.
    always @(negedge Clock) begin
        rd_seen = fifo_rd;
        if (fifo_rd) rd_count++;
        if (Reset) begin
            pos     = 0;
            fsum    = 8'd0;
            prev_wr = 1'b0;
        end else begin
            if (tx_wr) begin
                check("tx_ready_at_wr", tx_ready, 1);
                check("wr_back_to_back", prev_wr, 0);
                check("exp_available", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("tx_byte", tx_data, exp_b);
                end
                if (pos >= 2) fsum = fsum + tx_data;
                pos++;
                wr_count++;
            end
            if (frame_done) begin
                check("frame_sum_zero", fsum, 0);
                check("frame_len", pos, PL + 6);
                pos  = 0;
                fsum = 8'd0;
                done_count++;
            end
            prev_wr = tx_wr;
        end
    end

    task automatic load_payload();
        for (int i = 0; i < PL; i++) pl[i] = fifo_q[i];
    endtask

    task automatic expect_frame(input logic [7:0] seq);
        logic [7:0] s;
        s = seq + 8'(PL >> 8) + 8'(PL & 255);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(seq);
        exp_q.push_back(8'(PL >> 8));
        exp_q.push_back(8'(PL & 255));
        for (int i = 0; i < PL; i++) begin
            exp_q.push_back(pl[i]);
            s = s + pl[i];
        end
        exp_q.push_back(8'h00 - s);
    endtask

    task automatic wait_busy(input string tag);
        int n = 0;
        while (busy !== 1'b1 && n < 50) begin
            @(negedge Clock);
            n++;
        end
        check(tag, busy, 1);
    endtask

    task automatic wait_wr(input int target);
        int n = 0;
        while (wr_count < target && n < 2000) begin
            @(posedge Clock);
            n++;
        end
        check("wr_reached", wr_count >= target, 1);
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (done_count < target && n < 2000) begin
            @(posedge Clock);
            n++;
        end
        @(negedge Clock);
        check("frame_done_count", done_count, target);
        check("exp_drained", exp_q.size(), 0);
    endtask

    task automatic run_frame(input string tag);
        enable = 1'b1;
        wait_busy(tag);
        @(posedge Clock);
        #1 enable = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        int rd_snap;

        repeat (3) @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("rst_busy", busy, 0);
        check("rst_tx_wr", tx_wr, 0);
        check("rst_fifo_rd", fifo_rd, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_padded", padded, 0);
        check("rst_seq", seq_num, 0);
        check("rst_tx_data", tx_data, 0);

        // Enable gating, then the normal frame with enable dropped mid-frame
        for (int r = 0; r < 2; r++)
            for (int b = 1; b <= PL; b++) fifo_q.push_back(8'(b));
        repeat (6) @(negedge Clock);
        check("gate_busy", busy, 0);
        check("gate_wr", wr_count, 0);
        check("gate_rd", rd_count, 0);
        load_payload();
        expect_frame(seq_model);
        @(posedge Clock);
        #1 enable = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 5) begin
            @(negedge Clock);
            n++;
        end
        check("start_latency", (busy === 1'b1) && (n <= 2), 1);
        wait_wr(3);
        #1 enable = 1'b0;
        wait_frame(1);
        seq_model++;
        check("normal_seq", seq_num, seq_model);
        check("normal_padded", padded, 0);
        repeat (10) @(negedge Clock);
        check("no_restart_busy", busy, 0);
        check("no_restart_done", done_count, 1);
        check("no_restart_wr", wr_count, PL + 6);

        // Back-pressure on the UART side
        load_payload();
        expect_frame(seq_model);
        bp_en = 1'b1;
        run_frame("bp_start");
        wait_frame(2);
        bp_en = 1'b0;
        seq_model++;
        check("bp_seq", seq_num, seq_model);

        // Stall timeout: one real byte, then padding
        fifo_q.push_back(8'hAA);
        pl[0] = 8'hAA;
        for (int i = 1; i < PL; i++) pl[i] = PADB;
        expect_frame(seq_model);
        run_frame("pad_start");
        n = 0;
        while (padded !== 1'b1 && n < 200) begin
            @(negedge Clock);
            n++;
        end
        check("pad_entered", padded, 1);
        rd_snap = rd_count;
        fifo_q.push_back(8'hBB);
        wait_frame(3);
        seq_model++;
        check("pad_sticky", padded, 1);
        check("pad_no_reads", rd_count, rd_snap);
        check("pad_seq", seq_num, seq_model);

        // Reset after the second payload byte
        for (int b = 1; b <= 7; b++) fifo_q.push_back(8'(b * 17));
        load_payload();
        expect_frame(seq_model);
        base = wr_count;
        enable = 1'b1;
        wait_busy("rst_frame_start");
        check("pad_cleared", padded, 0);
        wait_wr(base + 7);
        #1;
        Reset = 1'b1;
        enable = 1'b0;
        exp_q.delete();
        seq_model = 8'd0;
        @(posedge Clock);
        #1 Reset = 1'b0;
        @(negedge Clock);
        check("midrst_busy", busy, 0);
        check("midrst_tx_wr", tx_wr, 0);
        check("midrst_fifo_rd", fifo_rd, 0);
        check("midrst_padded", padded, 0);
        check("midrst_seq", seq_num, 0);
        check("midrst_late_valid", fifo_valid, 1);
        base = wr_count;
        repeat (4) @(negedge Clock);
        check("midrst_no_wr", wr_count, base);
        check("midrst_idle", busy, 0);
        load_payload();
        expect_frame(seq_model);
        run_frame("post_rst_start");
        wait_frame(4);
        seq_model++;
        check("post_rst_seq", seq_num, seq_model);

        // Sequence number wrap over 257 frames
        for (int k = 0; k < 257; k++) begin
            for (int i = 0; i < PL; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
            load_payload();
            expect_frame(seq_model);
            run_frame("wrap_start");
            wait_frame(5 + k);
            seq_model++;
            check("wrap_seq", seq_num, seq_model);
        end
        check("wrap_final_seq", seq_num, 8'(1 + 257));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog expired");
    end

endmodule
